onchip_memory_arbiter: RTL and testbench

Two-requester arbiter in front of the 4096 x 32 single-port on-chip RAM (1-cycle read latency, byte enables, chipselect/write/clken control). It lets two Avalon-MM style requesters, typically the HPS bridge and a fabric DMA, share the one RAM port. Arbitration is per-cycle round-robin. Each requester gets a waitrequest/readdatavalid handshake, and read data is routed back only to the requester that issued the read.

---
 rtl/onchip_mem_arb_pkg.sv | 13 +
 rtl/onchip_memory_arbiter_if.sv | 24 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/onchip_memory_arbiter.sv | 67 ++++++
 tb/tb_onchip_memory_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// rtl/onchip_mem_arb_pkg.sv - shared widths and grant index type for the on-chip RAM arbiter
package onchip_mem_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        GNT_R0 = 1'b0,
        GNT_R1 = 1'b1
    } gnt_t;

endpackage

// File: rtl/onchip_memory_arbiter_if.sv
// rtl/onchip_memory_arbiter_if.sv - Avalon-MM style requester port into the RAM arbiter
interface onchip_memory_arbiter_if;
    import onchip_mem_arb_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way per-cycle round-robin picker owning the last_grant register
module rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output gnt_t       gnt_idx
);

    gnt_t last_grant;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = GNT_R0;
        if (!reset) begin
            case (req)
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = GNT_R0;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = GNT_R1;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = (last_grant == GNT_R0) ? GNT_R1 : GNT_R0;
                end
                default: ;
            endcase
        end
    end

    // Reset to R1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= GNT_R1;
        end else if (gnt_valid) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// rtl/onchip_memory_arbiter.sv - two-requester arbiter sharing one single-port 4096x32 on-chip RAM
module onchip_memory_arbiter
    import onchip_mem_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    onchip_memory_arbiter_if.slave  r0,
    onchip_memory_arbiter_if.slave  r1,
    output logic [ADDR_W-1:0]       mem_address,
    output logic [BE_W-1:0]         mem_byteenable,
    output logic                    mem_chipselect,
    output logic                    mem_write,
    output logic [DATA_W-1:0]       mem_writedata,
    output logic                    mem_clken,
    input  logic [DATA_W-1:0]       mem_readdata
);

    logic [1:0] req;
    logic       gnt_valid;
    gnt_t       gnt_idx;
    logic       sel_r1;
    logic       rd_accept;
    logic       rd_pend;
    gnt_t       rd_owner;

    assign req = {r1.read | r1.write, r0.read | r0.write};

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_r1 = gnt_valid && (gnt_idx == GNT_R1);

    assign r0.waitrequest = !(gnt_valid && (gnt_idx == GNT_R0));
    assign r1.waitrequest = !sel_r1;

    // With no grant the address/data lanes simply follow requester 0.
    assign mem_address    = sel_r1 ? r1.address    : r0.address;
    assign mem_byteenable = sel_r1 ? r1.byteenable : r0.byteenable;
    assign mem_writedata  = sel_r1 ? r1.writedata  : r0.writedata;
    assign mem_chipselect = gnt_valid;
    assign mem_write      = gnt_valid && (sel_r1 ? r1.write : r0.write);
    assign mem_clken      = 1'b1;

    // A simultaneous read+write is a write, so any non-write grant is a read.
    assign rd_accept = gnt_valid && !mem_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend  <= 1'b0;
            rd_owner <= GNT_R0;
        end else begin
            rd_pend  <= rd_accept;
            rd_owner <= gnt_idx;
        end
    end

    assign r0.readdata      = mem_readdata;
    assign r1.readdata      = mem_readdata;
    assign r0.readdatavalid = rd_pend && !reset && (rd_owner == GNT_R0);
    assign r1.readdatavalid = rd_pend && !reset && (rd_owner == GNT_R1);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// tb/tb_onchip_memory_arbiter.sv - directed vector bench for onchip_memory_arbiter with a RAM model
module tb_onchip_memory_arbiter;
    import onchip_mem_arb_pkg::*;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;

    typedef struct {
        logic [1:0]        op0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic [BE_W-1:0]   be0;
        logic [1:0]        op1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        logic [BE_W-1:0]   be1;
        int                gnt;
        int                vld;
        logic [DATA_W-1:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata = '0;

    logic [DATA_W-1:0] ram [0:4095];

    int errors = 0;
    int checks = 0;
    vec_t vecs [14];

    onchip_memory_arbiter_if r0_if ();
    onchip_memory_arbiter_if r1_if ();

    onchip_memory_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .r0             (r0_if),
        .r1             (r1_if),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {20'hC0DE0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            mem_readdata <= ram[mem_address];
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
                end
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] op0, input logic [ADDR_W-1:0] a0,
                                input logic [DATA_W-1:0] d0, input logic [BE_W-1:0] be0,
                                input logic [1:0] op1, input logic [ADDR_W-1:0] a1,
                                input logic [DATA_W-1:0] d1, input logic [BE_W-1:0] be1,
                                input int gnt, input int vld, input logic [DATA_W-1:0] rdata);
        vec_t v;
        v.op0 = op0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
        v.op1 = op1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
        v.gnt = gnt; v.vld = vld; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic [BE_W-1:0] be0,
                         input logic [1:0] op1, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1, input logic [BE_W-1:0] be1);
        r0_if.read = (op0 == OP_RD); r0_if.write = (op0 == OP_WR);
        r0_if.address = a0; r0_if.writedata = d0; r0_if.byteenable = be0;
        r1_if.read = (op1 == OP_RD); r1_if.write = (op1 == OP_WR);
        r1_if.address = a1; r1_if.writedata = d1; r1_if.byteenable = be1;
    endtask

    // gnt: 0 = r0, 1 = r1, 2 = none; vld: 0 = none, 1 = r0, 2 = r1
    task automatic check_cycle(input string tag, input int gnt, input int vld,
                               input logic [DATA_W-1:0] rdata, input logic [ADDR_W-1:0] exp_addr,
                               input logic exp_mw);
        chk({tag, " r0_waitrequest"}, 32'(r0_if.waitrequest), 32'(gnt != 0));
        chk({tag, " r1_waitrequest"}, 32'(r1_if.waitrequest), 32'(gnt != 1));
        chk({tag, " mem_chipselect"}, 32'(mem_chipselect), 32'(gnt != 2));
        chk({tag, " mem_write"}, 32'(mem_write), 32'(exp_mw));
        chk({tag, " mem_clken"}, 32'(mem_clken), 32'd1);
        if (gnt != 2) chk({tag, " mem_address"}, 32'(mem_address), 32'(exp_addr));
        chk({tag, " r0_readdatavalid"}, 32'(r0_if.readdatavalid), 32'(vld == 1));
        chk({tag, " r1_readdatavalid"}, 32'(r1_if.readdatavalid), 32'(vld == 2));
        if (vld == 1) chk({tag, " r0_readdata"}, r0_if.readdata, rdata);
        if (vld == 2) chk({tag, " r1_readdata"}, r1_if.readdata, rdata);
    endtask

    initial begin
        int prev_g;
        int i0;
        int i1;
        logic [ADDR_W-1:0] prev_a;
        logic [ADDR_W-1:0] ca0;
        logic [ADDR_W-1:0] ca1;
        logic exp_mw;

        for (int i = 0; i < 4096; i++) ram[i] = pat(12'(i));

        vecs[0]  = mk(OP_WR, 12'h010, 32'hDEADBEEF, 4'hF, OP_IDLE, 12'h000, 32'h0, 4'h0, 0, 0, 32'h0);
        vecs[1]  = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_RD, 12'h010, 32'h0, 4'h0, 1, 0, 32'h0);
        vecs[2]  = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0, 2, 2, 32'hDEADBEEF);
        vecs[3]  = mk(OP_WR, 12'h020, 32'h11223344, 4'hF, OP_IDLE, 12'h000, 32'h0, 4'h0, 0, 0, 32'h0);
        vecs[4]  = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_WR, 12'h020, 32'hAABBCCDD, 4'b0101, 1, 0, 32'h0);
        vecs[5]  = mk(OP_RD, 12'h020, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0, 0, 0, 32'h0);
        vecs[6]  = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_RD, 12'h010, 32'h0, 4'h0, 1, 1, 32'h11BB33DD);
        vecs[7]  = mk(OP_WR, 12'h030, 32'h01234567, 4'hF, OP_WR, 12'h031, 32'h89ABCDEF, 4'hF, 0, 2, 32'hDEADBEEF);
        vecs[8]  = mk(OP_WR, 12'h032, 32'h0F0F0F0F, 4'hF, OP_WR, 12'h031, 32'h89ABCDEF, 4'hF, 1, 0, 32'h0);
        vecs[9]  = mk(OP_WR, 12'h032, 32'h0F0F0F0F, 4'hF, OP_IDLE, 12'h000, 32'h0, 4'h0, 0, 0, 32'h0);
        vecs[10] = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_RD, 12'h030, 32'h0, 4'h0, 1, 0, 32'h0);
        vecs[11] = mk(OP_RD, 12'h031, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0, 0, 2, 32'h01234567);
        vecs[12] = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_RD, 12'h032, 32'h0, 4'h0, 1, 1, 32'h89ABCDEF);
        vecs[13] = mk(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0, 2, 2, 32'h0F0F0F0F);

        // Requests during reset must never be granted.
        reset = 1'b1;
        drive(OP_RD, 12'h001, 32'h0, 4'h0, OP_WR, 12'h002, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check_cycle($sformatf("reset[%0d]", k), 2, 0, 32'h0, 12'h000, 1'b0);
        end

        @(negedge clk);
        reset = 1'b0;
        drive(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            #1;
            check_cycle($sformatf("idle[%0d]", k), 2, 0, 32'h0, 12'h000, 1'b0);
            @(negedge clk);
        end

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op0, vecs[i].a0, vecs[i].d0, vecs[i].be0,
                  vecs[i].op1, vecs[i].a1, vecs[i].d1, vecs[i].be1);
            #1;
            exp_mw = (vecs[i].gnt == 0) ? (vecs[i].op0 == OP_WR) :
                     (vecs[i].gnt == 1) ? (vecs[i].op1 == OP_WR) : 1'b0;
            check_cycle($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].vld, vecs[i].rdata,
                        (vecs[i].gnt == 1) ? vecs[i].a1 : vecs[i].a0, exp_mw);
            @(negedge clk);
        end

        // Read accepted just before reset: its data-valid must never appear.
        drive(OP_RD, 12'h005, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0);
        #1;
        check_cycle("rst_mid accept", 0, 0, 32'h0, 12'h005, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_cycle($sformatf("rst_mid hold[%0d]", k), 2, 0, 32'h0, 12'h000, 1'b0);
            @(negedge clk);
        end
        reset = 1'b0;
        drive(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0);
        #1;
        check_cycle("rst_mid release", 2, 0, 32'h0, 12'h000, 1'b0);
        @(negedge clk);

        // Both read continuously: r0 wins first, then strict alternation with no bubbles.
        i0 = 0;
        i1 = 0;
        prev_g = -1;
        prev_a = '0;
        for (int k = 0; k < 16; k++) begin
            ca0 = 12'(i0);
            ca1 = 12'(8 + i1);
            drive(OP_RD, ca0, 32'h0, 4'h0, OP_RD, ca1, 32'h0, 4'h0);
            #1;
            check_cycle($sformatf("contend[%0d]", k), k % 2, (prev_g < 0) ? 0 : prev_g + 1,
                        pat(prev_a), (k % 2 == 1) ? ca1 : ca0, 1'b0);
            if (k % 2 == 1) begin
                prev_a = ca1;
                i1++;
            end else begin
                prev_a = ca0;
                i0++;
            end
            prev_g = k % 2;
            @(negedge clk);
        end
        drive(OP_IDLE, 12'h000, 32'h0, 4'h0, OP_IDLE, 12'h000, 32'h0, 4'h0);
        #1;
        check_cycle("contend drain", 2, prev_g + 1, pat(prev_a), 12'h000, 1'b0);
        @(negedge clk); #1;
        check_cycle("final idle", 2, 0, 32'h0, 12'h000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
